// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense layer datapath.
// Holds default Q8.8 widths, the streamer FSM state enum and the ReLU helper.
package dense_pkg;

    localparam int DENSE_WIDTH = 16;
    localparam int DENSE_FRAC  = 8;
    localparam int DENSE_MAXW  = 64;

    typedef enum logic {
        IDLE,
        STREAM
    } stream_state_e;

    // ReLU on a value of w significant bits, zero-extended into a 64-bit word.
    // Anything with its sign bit set becomes zero; everything else passes.
    function automatic logic [DENSE_MAXW-1:0] relu_fx(
        input logic [DENSE_MAXW-1:0] x,
        input int unsigned           w,
        input logic                  en
    );
        relu_fx = x;
        if (en && x[6'(w - 1)]) begin
            relu_fx = '0;
        end
    endfunction

endpackage

// File: rtl/dense_idx_counter.sv
// Nested batch/neuron index counter, neuron fastest, wrapping after [B-1][M-1].
// Ports: clk, rst_n, clr, inc in; batch, neuron, last out.
module dense_idx_counter #(
    parameter  int B  = 2,
    parameter  int M  = 3,
    localparam int BW = (B > 1) ? $clog2(B) : 1,
    localparam int NW = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [BW-1:0] batch,
    output logic [NW-1:0] neuron,
    output logic          last
);

    localparam logic [BW-1:0] BMAX = BW'(B - 1);
    localparam logic [NW-1:0] NMAX = NW'(M - 1);

    logic nwrap;

    assign nwrap = (neuron == NMAX);
    assign last  = nwrap && (batch == BMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            batch  <= '0;
            neuron <= '0;
        end else if (clr) begin
            batch  <= '0;
            neuron <= '0;
        end else if (inc) begin
            if (last) begin
                batch  <= '0;
                neuron <= '0;
            end else if (nwrap) begin
                batch  <= batch + 1'b1;
                neuron <= '0;
            end else begin
                neuron <= neuron + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dense_result_streamer.sv
// Snapshots a parallel result[B][M] array and drains it as a valid/ready stream.
// Ports: clk, rst_n, start, result, s_ready in; busy, s_valid, s_data, s_batch, s_neuron, s_last, done out.
module dense_result_streamer
    import dense_pkg::*;
#(
    parameter  int B     = 2,
    parameter  int M     = 3,
    parameter  int WIDTH = DENSE_WIDTH,
    parameter  int FRAC  = DENSE_FRAC,
    parameter  int RELU  = 0,
    localparam int BW    = (B > 1) ? $clog2(B) : 1,
    localparam int NW    = (M > 1) ? $clog2(M) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic signed [B-1:0][M-1:0][WIDTH-1:0] result,
    output logic                                busy,
    output logic                                s_valid,
    input  logic                                s_ready,
    output logic signed [WIDTH-1:0]             s_data,
    output logic [BW-1:0]                       s_batch,
    output logic [NW-1:0]                       s_neuron,
    output logic                                s_last,
    output logic                                done
);

    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("FRAC must lie in [0, WIDTH)");
    end

    stream_state_e state_q;
    stream_state_e state_d;

    logic [B-1:0][M-1:0][WIDTH-1:0] mem_q;
    logic [B-1:0][M-1:0][WIDTH-1:0] cap_val;
    logic                           cap;
    logic                           hs;
    logic                           streaming;
    logic                           cnt_last;
    logic                           done_q;

    assign streaming = (state_q == STREAM);
    assign hs        = streaming && s_ready;

    for (genvar bi = 0; bi < B; bi++) begin : g_b
        for (genvar mi = 0; mi < M; mi++) begin : g_m
            logic [DENSE_MAXW-1:0] rv;
            logic                  unused_hi;
            assign rv = relu_fx(DENSE_MAXW'(result[bi][mi]), WIDTH, RELU != 0);
            assign cap_val[bi][mi] = rv[WIDTH-1:0];
            assign unused_hi = ^rv[DENSE_MAXW-1:WIDTH];
        end
    end

    dense_idx_counter #(
        .B(B),
        .M(M)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cap),
        .inc   (hs),
        .batch (s_batch),
        .neuron(s_neuron),
        .last  (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cap     = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (s_ready && cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= hs && cnt_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (cap) begin
            mem_q <= cap_val;
        end
    end

    // Counters idle at [0][0], so masking the data keeps it zero outside STREAM.
    assign busy    = streaming;
    assign s_valid = streaming;
    assign s_last  = streaming && cnt_last;
    assign s_data  = streaming ? mem_q[s_batch][s_neuron] : '0;
    assign done    = done_q;

endmodule

// File: tb/tb_dense_result_streamer.sv
// Directed bench for dense_result_streamer: drain, backpressure, ReLU,
// capture isolation, async reset and the single-element back-to-back case.
module tb_dense_result_streamer;

    typedef struct {
        logic [15:0] data;
        int          b;
        int          n;
        logic        last;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic st0, st1, st2, rd0, rd1, rd2;
    logic [1:0][2:0][15:0] res0, res1;
    logic [0:0][0:0][15:0] res2;

    logic bz0, sv0, sl0, dn0, sb0;
    logic [15:0] sd0;
    logic [1:0]  sn0;
    logic bz1, sv1, sl1, dn1, sb1;
    logic [15:0] sd1;
    logic [1:0]  sn1;
    logic bz2, sv2, sl2, dn2, sb2, sn2;
    logic [15:0] sd2;

    int pass_cnt = 0;
    int total_cnt = 0;

    vec_t v0[6];
    vec_t v1[6];

    dense_result_streamer #(.B(2), .M(3), .WIDTH(16), .FRAC(8), .RELU(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .result(res0),
        .busy(bz0), .s_valid(sv0), .s_ready(rd0), .s_data(sd0),
        .s_batch(sb0), .s_neuron(sn0), .s_last(sl0), .done(dn0)
    );

    dense_result_streamer #(.B(2), .M(3), .WIDTH(16), .FRAC(8), .RELU(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .result(res1),
        .busy(bz1), .s_valid(sv1), .s_ready(rd1), .s_data(sd1),
        .s_batch(sb1), .s_neuron(sn1), .s_last(sl1), .done(dn1)
    );

    dense_result_streamer #(.B(1), .M(1), .WIDTH(16), .FRAC(8), .RELU(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .result(res2),
        .busy(bz2), .s_valid(sv2), .s_ready(rd2), .s_data(sd2),
        .s_batch(sb2), .s_neuron(sn2), .s_last(sl2), .done(dn2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_base(input int sel);
        logic [1:0][2:0][15:0] r;
        r[0][0] = 16'h0180; r[0][1] = 16'hFF00; r[0][2] = 16'h0040;
        r[1][0] = 16'h0000; r[1][1] = 16'h7FFF; r[1][2] = 16'h8000;
        if (sel == 0) res0 = r;
        else          res1 = r;
    endtask

    // Called at a negedge: start is seen at the next posedge.
    task automatic start_pulse(input int sel);
        if (sel == 0) st0 = 1'b1;
        else          st1 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        st1 = 1'b0;
    endtask

    task automatic run_stream(input int sel, input bit bp, input bit iso,
                              input string tg);
        int   idx = 0;
        int   dn  = 0;
        int   cyc = 0;
        bit   pat[4];
        logic vld, lst, dnv, bzv, r, s;
        logic [15:0] d;
        int   b, n;
        vec_t e;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (cyc < 80 && dn == 0) begin
            if (sel == 0) begin
                vld = sv0; lst = sl0; dnv = dn0; bzv = bz0;
                d = sd0; b = int'(sb0); n = int'(sn0);
            end else begin
                vld = sv1; lst = sl1; dnv = dn1; bzv = bz1;
                d = sd1; b = int'(sb1); n = int'(sn1);
            end
            s = 1'b0;
            if (dnv) begin
                dn++;
                chk({tg, "_done_valid"}, {31'd0, vld}, 32'd0);
                chk({tg, "_done_busy"}, {31'd0, bzv}, 32'd0);
            end else if (idx > 5) begin
                chk({tg, "_overrun"}, idx, 32'd5);
                cyc = 80;
            end else begin
                e = (sel == 0) ? v0[idx] : v1[idx];
                chk({tg, "_valid"}, {31'd0, vld}, 32'd1);
                chk({tg, "_data"}, {16'd0, d}, {16'd0, e.data});
                chk({tg, "_batch"}, b, e.b);
                chk({tg, "_neuron"}, n, e.n);
                chk({tg, "_last"}, {31'd0, lst}, {31'd0, e.last});
                r = bp ? pat[cyc % 4] : 1'b1;
                if (iso && (cyc == 1 || e.last)) s = 1'b1;
                if (r) idx++;
                if (sel == 0) rd0 = r;
                else          rd1 = r;
            end
            if (sel == 0) st0 = s;
            else          st1 = s;
            @(negedge clk);
            cyc++;
        end
        st0 = 1'b0;
        st1 = 1'b0;
        chk({tg, "_handshakes"}, idx, 32'd6);
        chk({tg, "_done_seen"}, dn, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk({tg, "_idle_valid"}, {31'd0, (sel == 0) ? sv0 : sv1}, 32'd0);
            chk({tg, "_idle_done"}, {31'd0, (sel == 0) ? dn0 : dn1}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        v0[0] = '{16'h0180, 0, 0, 1'b0};
        v0[1] = '{16'hFF00, 0, 1, 1'b0};
        v0[2] = '{16'h0040, 0, 2, 1'b0};
        v0[3] = '{16'h0000, 1, 0, 1'b0};
        v0[4] = '{16'h7FFF, 1, 1, 1'b0};
        v0[5] = '{16'h8000, 1, 2, 1'b1};
        v1[0] = '{16'h0180, 0, 0, 1'b0};
        v1[1] = '{16'h0000, 0, 1, 1'b0};
        v1[2] = '{16'h0040, 0, 2, 1'b0};
        v1[3] = '{16'h0000, 1, 0, 1'b0};
        v1[4] = '{16'h7FFF, 1, 1, 1'b0};
        v1[5] = '{16'h0000, 1, 2, 1'b1};

        rst_n = 1'b0;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        rd0 = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
        set_base(0);
        set_base(1);
        res2 = 16'hFE80;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bz0}, 32'd0);
        chk("rst_valid", {31'd0, sv0}, 32'd0);
        chk("rst_last", {31'd0, sl0}, 32'd0);
        chk("rst_done", {31'd0, dn0}, 32'd0);
        chk("rst_data", {16'd0, sd0}, 32'd0);
        chk("rst_tags", {29'd0, sb0, sn0}, 32'd0);
        chk("rst_last_b1m1", {31'd0, sl2}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        start_pulse(0);
        run_stream(0, 1'b0, 1'b0, "basic");

        start_pulse(0);
        run_stream(0, 1'b1, 1'b0, "bp");

        start_pulse(1);
        run_stream(1, 1'b0, 1'b0, "relu");

        start_pulse(0);
        res0 = {6{16'h1111}};
        run_stream(0, 1'b1, 1'b1, "iso");
        set_base(0);

        rd0 = 1'b1;
        start_pulse(0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_neuron", {30'd0, sn0}, 32'd2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, sv0}, 32'd0);
        chk("arst_busy", {31'd0, bz0}, 32'd0);
        chk("arst_done", {31'd0, dn0}, 32'd0);
        chk("arst_tags", {29'd0, sb0, sn0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, sv0, dn0}, 32'd0);
        start_pulse(0);
        run_stream(0, 1'b0, 1'b0, "replay");

        rd2 = 1'b1;
        st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        chk("one_valid", {31'd0, sv2}, 32'd1);
        chk("one_data", {16'd0, sd2}, 32'h0000FE80);
        chk("one_last", {31'd0, sl2}, 32'd1);
        chk("one_tags", {30'd0, sb2, sn2}, 32'd0);
        @(negedge clk);
        chk("one_done", {31'd0, dn2}, 32'd1);
        chk("one_done_valid", {31'd0, sv2}, 32'd0);
        st2 = 1'b1;
        @(negedge clk);
        st2 = 1'b0;
        chk("b2b_valid", {31'd0, sv2}, 32'd1);
        chk("b2b_data", {16'd0, sd2}, 32'h0000FE80);
        chk("b2b_last", {31'd0, sl2}, 32'd1);
        chk("b2b_nodone", {31'd0, dn2}, 32'd0);
        @(negedge clk);
        chk("b2b_done", {31'd0, dn2}, 32'd1);
        @(negedge clk);
        chk("b2b_done_once", {31'd0, dn2}, 32'd0);
        chk("b2b_idle", {31'd0, sv2}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
